four_bit_adder_two_by_two: RTL and testbench

//   4-bit binary adder with carry-in and carry-out, built as two cascaded 2-bit slices.

---
 rtl/four_bit_adder_two_by_two_if.sv | 20 ++
 rtl/four_bit_adder_two_by_two.sv | 75 +++++++
 tb/tb_four_bit_adder_two_by_two.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/four_bit_adder_two_by_two_if.sv
// Operand/result bundle for the two-stage 4-bit adder.
interface four_bit_adder_two_by_two_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  s, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output s, cout, out_valid
  );
endinterface

// File: rtl/four_bit_adder_two_by_two.sv
// 4-bit adder built from two 2-bit ripple slices with a pipeline register between them.
// Results appear two rising edges after the operands are sampled; one operand set per cycle.
module four_bit_adder_two_by_two (
  input  logic                          clk,
  input  logic                          rst_n,
  four_bit_adder_two_by_two_if.slave    bus
);

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  logic [1:0] s_lo_d, s_lo_q;
  logic       c2_d, c2_q;
  logic [1:0] a_hi_d, a_hi_q;
  logic [1:0] b_hi_d, b_hi_q;
  logic       v1_d, v1_q;
  logic [3:0] s_d, s_q;
  logic       cout_d, cout_q;
  logic       out_valid_d, out_valid_q;

  logic       c1;
  logic       c3;
  logic [1:0] s_hi;

  always_comb begin
    c1     = 1'b0;
    s_lo_d = '0;
    c2_d   = 1'b0;
    {c1, s_lo_d[0]}   = full_add(bus.a[0], bus.b[0], bus.cin);
    {c2_d, s_lo_d[1]} = full_add(bus.a[1], bus.b[1], c1);
    a_hi_d = bus.a[3:2];
    b_hi_d = bus.b[3:2];
    v1_d   = bus.in_valid;
  end

  // The high slice only sees the registered slice-boundary carry.
  always_comb begin
    c3     = 1'b0;
    s_hi   = '0;
    cout_d = 1'b0;
    {c3, s_hi[0]}     = full_add(a_hi_q[0], b_hi_q[0], c2_q);
    {cout_d, s_hi[1]} = full_add(a_hi_q[1], b_hi_q[1], c3);
    s_d         = {s_hi, s_lo_q};
    out_valid_d = v1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_lo_q      <= '0;
      c2_q        <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      v1_q        <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_lo_q      <= s_lo_d;
      c2_q        <= c2_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      v1_q        <= v1_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_four_bit_adder_two_by_two.sv
// Scoreboard bench: driver queues a + b + cin with its due cycle, monitor checks on out_valid.
module tb_four_bit_adder_two_by_two;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   chk_en;

  typedef struct {
    logic [4:0] sum;
    int         due;
  } exp_t;

  exp_t sb[$];

  four_bit_adder_two_by_two_if bus ();

  four_bit_adder_two_by_two dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    if (v) begin
      e.sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      e.due = cyc + 2;
      sb.push_back(e);
    end
  endtask

  // Monitor: every presented result must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got sum %0h want none at cycle %0d",
                   {bus.cout, bus.s}, cyc);
        end else begin
          e = sb.pop_front();
          if ({bus.cout, bus.s} !== e.sum || cyc != e.due) begin
            errors++;
            $display("FAIL result got sum %0h cycle %0d want sum %0h cycle %0d",
                     {bus.cout, bus.s}, cyc, e.sum, e.due);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_valid got out_valid 0 want sum %0h due %0d at cycle %0d",
                 e.sum, e.due, cyc);
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    chk_en       = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;

    #1;
    check_val("reset_s", {4'b0, bus.s}, 8'h0);
    check_val("reset_cout", {7'b0, bus.cout}, 8'h0);
    check_val("reset_valid", {7'b0, bus.out_valid}, 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed corners, then back-to-back pair.
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    drive(4'h3, 4'h1, 1'b0, 1'b1);
    drive(4'hF, 4'h0, 1'b1, 1'b1);
    drive(4'hF, 4'hF, 1'b1, 1'b1);
    drive(4'h7, 4'h8, 1'b1, 1'b1);
    drive(4'h2, 4'h1, 1'b0, 1'b1);
    drive(4'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      drive(i[3:0], i[7:4], i[8], 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    // Reset mid-stream while a result is being presented.
    drive(4'h9, 4'h9, 1'b0, 1'b1);
    drive(4'h5, 4'hA, 1'b1, 1'b1);
    drive(4'h1, 4'h2, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check_val("pre_reset_valid", {7'b0, bus.out_valid}, 8'h1);
    chk_en       = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_val("midreset_s", {4'b0, bus.s}, 8'h0);
    check_val("midreset_cout", {7'b0, bus.cout}, 8'h0);
    check_val("midreset_valid", {7'b0, bus.out_valid}, 8'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    drive(4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h3, 4'h1, 1'b0, 1'b1);
    repeat (5) drive(4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("drain_empty", 8'(sb.size()), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
